// File: rtl/simd_mult_pkg.sv
// Shared constants and tag type for the SIMD multiplier scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package simd_mult_pkg;

    localparam int LANES         = 32;
    localparam int LANE_W        = 16;
    localparam int VEC_WIDTH_BIT = LANES * LANE_W;

    // Widest requester id carried by a tag (up to 8 requesters).
    localparam int ID_W_MAX = 3;

    // One in-flight operation marker travelling alongside the array pipeline.
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    // Bits needed to name one of n requesters (at least one bit).
    function automatic int id_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/simd_rsp_fifo.sv
// Synchronous show-ahead FIFO holding tagged products; exposes its fill count.
// Latency: a write is visible at the head the cycle after it is written.
// Backpressure: pop only on rd_vld && rd_rdy; writes are never refused, so the writer must hold credit.
module simd_rsp_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          full;
    logic          do_rd;

    assign full   = (cnt_q == CW'(DEPTH));
    assign rd_vld = (cnt_q != '0);
    assign do_rd  = rd_vld && rd_rdy;
    assign count  = cnt_q;
    // Head reads as zero while empty so the outputs are clean after reset.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_vld, do_rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // The scheduler's credit scheme must make a write into a full FIFO impossible.
    no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_vld && full));

endmodule

// File: rtl/simd_mult_sched.sv
// Round-robin scheduler sharing one pipelined SIMD multiplier array among requesters; optional perf counters under SIMD_MULT_SCHED_PERF_EN.
// Latency: handshake to rsp_valid is MULT_LATENCY+2 cycles into an empty response FIFO.
// Backpressure: issues only while in-flight ops plus FIFO entries stay below RSP_DEPTH, so no product is dropped.
module simd_mult_sched
    import simd_mult_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_WIDTH_BIT = VEC_WIDTH_BIT,
    parameter  int MULT_LATENCY   = 3,
    parameter  int RSP_DEPTH      = 8,
    localparam int ID_W           = id_bits(NUM_REQ),
    localparam int CNT_W          = $clog2(RSP_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DATA_WIDTH_BIT-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH_BIT-1:0] req_b,
    output logic [DATA_WIDTH_BIT-1:0]         mult_a,
    output logic [DATA_WIDTH_BIT-1:0]         mult_b,
    input  logic [DATA_WIDTH_BIT-1:0]         mult_p,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ID_W-1:0]                   rsp_id,
    output logic [DATA_WIDTH_BIT-1:0]         rsp_data,
`ifdef SIMD_MULT_SCHED_PERF_EN
    output logic                              busy,
    output logic [31:0]                       perf_issued,
    output logic [31:0]                       perf_stall
`else
    output logic                              busy
`endif
);

    logic [ID_W-1:0]           rr_ptr;
    logic                      grant_vld;
    logic [ID_W-1:0]           grant_id;
    logic                      credit_ok;
    logic                      hs;
    logic [DATA_WIDTH_BIT-1:0] sel_a;
    logic [DATA_WIDTH_BIT-1:0] sel_b;
    tag_t                      tag_q [MULT_LATENCY+1];
    logic                      capture;
    logic [CNT_W-1:0]          in_flight;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W:0]            occupancy;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!grant_vld && req_valid[idx_w]) begin
                grant_vld = 1'b1;
                grant_id  = idx_w;
            end
        end
    end

    // Credit covers every op that could still land in the FIFO; a pop this cycle is not counted.
    always_comb begin
        occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
        credit_ok = (occupancy < (CNT_W+1)'(RSP_DEPTH));
        req_ready = '0;
        if (!rst && grant_vld && credit_ok) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign hs    = |req_ready;
    assign sel_a = req_a[int'(grant_id)*DATA_WIDTH_BIT +: DATA_WIDTH_BIT];
    assign sel_b = req_b[int'(grant_id)*DATA_WIDTH_BIT +: DATA_WIDTH_BIT];

    // Pointer moves just past the winner only when an op is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (hs) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end

    // Operand registers feeding the array; they hold when nothing is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_a <= '0;
            mult_b <= '0;
        end else if (hs) begin
            mult_a <= sel_a;
            mult_b <= sel_b;
        end
    end

    // Tag pipe mirrors the operand register plus the array stages, so the tail lines up with mult_p.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MULT_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: hs, id: ID_W_MAX'(grant_id)};
            for (int i = 1; i <= MULT_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign capture = tag_q[MULT_LATENCY].valid;

    // Count of ops issued to the array whose products have not yet been captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({hs, capture})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    simd_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (ID_W + DATA_WIDTH_BIT)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (capture),
        .wr_dat ({tag_q[MULT_LATENCY].id[ID_W-1:0], mult_p}),
        .rd_vld (rsp_valid),
        .rd_rdy (rsp_ready),
        .rd_dat ({rsp_id, rsp_data}),
        .count  (fifo_count)
    );

    assign busy = (in_flight != '0) || (fifo_count != '0);

`ifdef SIMD_MULT_SCHED_PERF_EN
    // Wrap-around counters of accepted ops and of cycles where demand went unserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (hs) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if ((|req_valid) && !hs) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_simd_mult_sched.sv
// Self-checking bench for simd_mult_sched with a behavioural multiplier array model.
// Latency: n/a.
// Backpressure: exercised through rsp_ready and the credit limit.
module tb_simd_mult_sched;
    import simd_mult_pkg::*;

    localparam int NR    = 4;
    localparam int DW    = 512;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [DW-1:0]   mult_a;
    logic [DW-1:0]   mult_b;
    logic [DW-1:0]   mult_p;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            busy;
`ifdef SIMD_MULT_SCHED_PERF_EN
    logic [31:0]     perf_issued;
    logic [31:0]     perf_stall;
`endif

    always #5 clk = ~clk;

    simd_mult_sched #(
        .NUM_REQ        (NR),
        .DATA_WIDTH_BIT (DW),
        .MULT_LATENCY   (LAT),
        .RSP_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_p      (mult_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
`ifdef SIMD_MULT_SCHED_PERF_EN
        .busy        (busy),
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`else
        .busy        (busy)
`endif
    );

    function automatic logic [DW-1:0] mul_vec(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [31:0]   full;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            full = a[l*16 +: 16] * b[l*16 +: 16];
            r[l*16 +: 16] = full[15:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    // Behavioural fixed-latency multiplier array.
    logic [DW-1:0] p_pipe [LAT];
    always @(posedge clk) begin
        p_pipe[0] <= mul_vec(mult_a, mult_b);
        for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign mult_p = p_pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on handshake, pop and compare on response pop.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            check("ready_onehot", DW'($countones(req_ready) <= 1), DW'(1));
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", DW'(sb.size() != 0), DW'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_id", DW'(rsp_id), DW'(e.id));
                    check("rsp_data", rsp_data, e.data);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = 2'(i);
                    e.data = mul_vec(req_a[i*DW +: DW], req_b[i*DW +: DW]);
                    sb.push_back(e);
                    hs_count++;
                end
            end
        end
    end

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;
    vec_t vecs[6];

    int            lat;
    logic [1:0]    gid;
    logic [DW-1:0] gdat;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [DW-1:0] vexp;
    int            base;
    int            seen;

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && !(busy == 1'b0 && sb.size() == 0); c++) @(negedge clk);
        check("drain_busy", DW'(busy), DW'(0));
        check("drain_sb_empty", DW'(sb.size()), DW'(0));
        @(posedge clk); #1;
    endtask

    task automatic run_single(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              output int l, output logic [1:0] oid, output logic [DW-1:0] od);
        bit accepted;
        accepted = 1'b0;
        l = 0;
        oid = '0;
        od = '0;
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_valid = '0;
        req_valid[id] = 1'b1;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            if (req_ready[id]) accepted = 1'b1;
        end
        check("single_accepted", DW'(accepted), DW'(1));
        @(posedge clk); #1 req_valid = '0;
        for (int c = 1; c <= 15 && l == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                l = c;
                oid = rsp_id;
                od = rsp_data;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{2, 16'h0003, 16'h0005, 16'h000F};
        vecs[1] = '{0, 16'h0100, 16'h0100, 16'h0000};
        vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 16'h0001};
        vecs[3] = '{3, 16'h1234, 16'h0002, 16'h2468};
        vecs[4] = '{1, 16'h00FF, 16'h0101, 16'hFFFF};
        vecs[5] = '{0, 16'h8000, 16'h0002, 16'h0000};

        // Reset state
        @(negedge clk);
        check("ready_in_reset", DW'(req_ready), DW'(0));
        @(posedge clk); #1 rst = 1'b0; req_valid = '0;
        @(negedge clk);
        check("rst_mult_a", mult_a, '0);
        check("rst_mult_b", mult_b, '0);
        check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        check("rst_rsp_id", DW'(rsp_id), DW'(0));
        check("rst_rsp_data", rsp_data, '0);
        check("rst_busy", DW'(busy), DW'(0));
        @(posedge clk); #1;

        // Table-driven single ops
        for (int v = 0; v < 6; v++) begin
            run_single(vecs[v].id, rep(vecs[v].a), rep(vecs[v].b), lat, gid, gdat);
            check($sformatf("vec%0d_latency", v), DW'(lat), DW'(5));
            check($sformatf("vec%0d_id", v), DW'(gid), DW'(vecs[v].id));
            check($sformatf("vec%0d_data", v), gdat, rep(vecs[v].p));
        end
        wait_drain();

        // Lane truncation in lane 7, other lanes independent
        for (int l = 0; l < LANES; l++) begin
            va[l*16 +: 16] = 16'(l + 1);
            vb[l*16 +: 16] = 16'h0002;
            vexp[l*16 +: 16] = 16'(2 * (l + 1));
        end
        va[7*16 +: 16] = 16'h0100;
        vb[7*16 +: 16] = 16'h0100;
        vexp[7*16 +: 16] = 16'h0000;
        run_single(1, va, vb, lat, gid, gdat);
        check("trunc_latency", DW'(lat), DW'(5));
        check("trunc_lane7", DW'(gdat[7*16 +: 16]), DW'(0));
        check("trunc_vector", gdat, vexp);
        wait_drain();

        // Fairness
        pulse_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = rep(16'(i + 1));
            req_b[i*DW +: DW] = rep(16'h0010);
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("fair_grant%0d", k), DW'(req_ready), DW'(1 << (k % 4)));
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_drain();

        // Backpressure and credit
        rsp_ready = 1'b0;
        req_a[0 +: DW] = rep(16'h0007);
        req_b[0 +: DW] = rep(16'h0003);
        req_valid = 4'b0001;
        base = hs_count;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_accepted", DW'(hs_count - base), DW'(8));
        check("bp_ready_low", DW'(req_ready), DW'(0));
        check("bp_rsp_valid", DW'(rsp_valid), DW'(1));
        check("bp_busy", DW'(busy), DW'(1));
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle_credit", DW'(req_ready), DW'(0));
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_reaccept", DW'(req_ready), DW'(1));
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_total", DW'(hs_count - base), DW'(9));
        check("bp_ready_low_again", DW'(req_ready), DW'(0));
        @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1;
        wait_drain();

        // Reset with ops in flight
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = rep(16'(3 * i + 2));
            req_b[i*DW +: DW] = rep(16'h0009);
        end
        base = hs_count;
        req_valid = 4'b0111;
        repeat (3) @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("mid_issued", DW'(hs_count - base), DW'(3));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_busy_after_rst", DW'(busy), DW'(0));
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        check("mid_no_rsp", DW'(seen), DW'(0));
        check("mid_busy", DW'(busy), DW'(0));
        @(posedge clk); #1 req_valid = '1;
        @(negedge clk);
        check("mid_rr_restart", DW'(req_ready), DW'(1));
        @(posedge clk); #1 req_valid = '0;
        wait_drain();

`ifdef SIMD_MULT_SCHED_PERF_EN
        // Performance counters: 8 accepts + 4 stalls, then 2 more accepts
        pulse_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        repeat (12) @(posedge clk);
        #1 req_valid = '0; rsp_ready = 1'b1;
        wait_drain();
        req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1 req_valid = '0;
        wait_drain();
        @(negedge clk);
        check("perf_issued", DW'(perf_issued), DW'(10));
        check("perf_stall", DW'(perf_stall), DW'(4));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
